// File: rtl/int_priority_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller: FSM encoding,
// default handler vectors, source count and the return-stack entry layout.
package int_priority_ctrl_pkg;

    localparam int NUM_SRC     = 3;
    localparam int STACK_DEPTH = 3;

    localparam logic [31:0] DEF_VEC1 = 32'h0000_1000;
    localparam logic [31:0] DEF_VEC2 = 32'h0000_1100;
    localparam logic [31:0] DEF_VEC3 = 32'h0000_1200;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTER = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // One saved context: where to return to and the level that was interrupted.
    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  lvl;
    } stk_entry_t;

    // One-hot pending bit belonging to a priority level (level k -> bit k-1).
    function automatic logic [NUM_SRC-1:0] src_mask(input logic [1:0] lvl);
        logic [NUM_SRC-1:0] m;
        m = '0;
        case (lvl)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/int_priority_ctrl_epc_stack.sv
// Three-deep LIFO of saved return contexts. Nesting only ever goes to a
// strictly higher level, so at most three entries can be live at once.
module epc_stack
    import int_priority_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  stk_entry_t push_data,
    output stk_entry_t top,
    output logic       empty
);

    localparam logic [1:0] FULL_COUNT = 2'(STACK_DEPTH);

    stk_entry_t mem [STACK_DEPTH];
    logic [1:0] count;

    // Storage and occupancy; push and pop are never requested together,
    // push is listed first only to make the update unambiguous.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= 2'd0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && (count != FULL_COUNT)) begin
            mem[count] <= push_data;
            count      <= count + 2'd1;
        end else if (pop && (count != 2'd0)) begin
            count <= count - 2'd1;
        end
    end

    // Top of stack reads as zero when nothing is saved.
    always_comb begin
        empty = (count == 2'd0);
        top   = '0;
        if (!empty) begin
            top = mem[count - 2'd1];
        end
    end

endmodule

// File: rtl/int_priority_ctrl.sv
// Nested, prioritised interrupt entry for a simple in-order pipeline.
// Request edges are latched into pending; the highest pending source that
// outranks the current level redirects EX to its handler, saving the return
// address and interrupted level on a small stack that ERET unwinds.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal execution, entry may be taken when EX accepts
// ST_ENTER | redirect cycle: int_req high, pipeline flushed to handler
// ST_GUARD | one-cycle hold so a handler instruction reaches EX first
module int_priority_ctrl
    import int_priority_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC1 = DEF_VEC1,
    parameter logic [31:0] VEC2 = DEF_VEC2,
    parameter logic [31:0] VEC3 = DEF_VEC3
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic [2:0]  ir,
    input  logic        accept,
    input  logic [31:0] resume_pc,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] int_vec,
    output logic [31:0] epc,
    output logic [1:0]  level,
    output logic [2:0]  pending
);

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         ir_q;
    logic [2:0]         ir_rise;
    logic [1:0]         cand_lvl;
    logic [31:0]        cand_vec;
    logic               take;
    logic               do_pop;
    logic [2:0]         take_mask;
    stk_entry_t         push_data;
    stk_entry_t         stk_top;
    logic               stk_empty;

    assign ir_rise = ir & ~ir_q;

    // Highest pending source wins: 3 over 2 over 1.
    always_comb begin
        cand_lvl = 2'd0;
        if (pending[2]) begin
            cand_lvl = 2'd3;
        end else if (pending[1]) begin
            cand_lvl = 2'd2;
        end else if (pending[0]) begin
            cand_lvl = 2'd1;
        end
    end

    // Handler address of the current candidate.
    always_comb begin
        cand_vec = '0;
        case (cand_lvl)
            2'd1:    cand_vec = VEC1;
            2'd2:    cand_vec = VEC2;
            2'd3:    cand_vec = VEC3;
            default: cand_vec = '0;
        endcase
    end

    // An ERET in the same cycle blocks entry; the restored level is used to
    // re-evaluate the candidate on the next cycle.
    always_comb begin
        do_pop    = eret & ~stk_empty;
        take      = (state == ST_RUN) && accept && !eret && (cand_lvl > level);
        take_mask = take ? src_mask(cand_lvl) : 3'b000;
        push_data = '{pc: resume_pc, lvl: level};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and redirect strobe.
    always_comb begin
        state_nxt = state;
        int_req   = 1'b0;
        case (state)
            ST_RUN: begin
                if (take) begin
                    state_nxt = ST_ENTER;
                end
            end
            ST_ENTER: begin
                int_req   = 1'b1;
                state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Request edge capture. The serviced bit is cleared before new edges are
    // merged, so a fresh edge arriving on the entry cycle stays pending.
    always_ff @(posedge clk) begin
        if (CLR) begin
            ir_q    <= 3'b000;
            pending <= 3'b000;
        end else begin
            ir_q    <= ir;
            pending <= (pending & ~take_mask) | ir_rise;
        end
    end

    // In-service level and latched handler vector.
    always_ff @(posedge clk) begin
        if (CLR) begin
            level   <= 2'd0;
            int_vec <= 32'h0;
        end else if (do_pop) begin
            level <= stk_top.lvl;
        end else if (take) begin
            level   <= cand_lvl;
            int_vec <= cand_vec;
        end
    end

    epc_stack u_epc_stack (
        .clk       (clk),
        .clr       (CLR),
        .push      (take),
        .pop       (do_pop),
        .push_data (push_data),
        .top       (stk_top),
        .empty     (stk_empty)
    );

    assign epc = stk_top.pc;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Scoreboard bench for int_priority_ctrl: a behavioural model predicts each
// handler entry and the visible level/pending/epc; a monitor compares.
module tb_int_priority_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [2:0]  ir = 3'b000;
    logic        accept = 1'b0;
    logic [31:0] resume_pc = 32'h0;
    logic        eret = 1'b0;
    logic        int_req;
    logic [31:0] int_vec;
    logic [31:0] epc;
    logic [1:0]  level;
    logic [2:0]  pending;

    int n_checks = 0;
    int n_pass   = 0;
    bit run_mon  = 1'b0;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] pc;
        logic [1:0]  lvl;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_stk_pc[$];
    int          m_stk_lvl[$];
    bit          m_pend[3];
    bit          m_irq[3];
    int          m_lvl  = 0;
    int          m_busy = 0;

    int_priority_ctrl dut (
        .clk       (clk),
        .CLR       (clr),
        .ir        (ir),
        .accept    (accept),
        .resume_pc (resume_pc),
        .eret      (eret),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .epc       (epc),
        .level     (level),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vec_of(input int src);
        case (src)
            1: return 32'h0000_1000;
            2: return 32'h0000_1100;
            3: return 32'h0000_1200;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_epc();
        return (m_stk_pc.size() == 0) ? 32'h0 : m_stk_pc[m_stk_pc.size()-1];
    endfunction

    function automatic logic [2:0] m_pend_vec();
        return {m_pend[2], m_pend[1], m_pend[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: evaluated from the same inputs the DUT sees at each edge.
    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < 3; k++) begin m_pend[k] = 0; m_irq[k] = 0; end
            m_stk_pc.delete();
            m_stk_lvl.delete();
            m_lvl  = 0;
            m_busy = 0;
        end else begin
            int  cand;
            bit  enter;
            cand = 0;
            for (int k = 0; k < 3; k++) if (m_pend[k]) cand = k + 1;
            enter = (m_busy == 0) && accept && !eret && (cand > m_lvl);
            if (eret && m_stk_lvl.size() > 0) begin
                m_lvl = m_stk_lvl.pop_back();
                void'(m_stk_pc.pop_back());
            end
            if (enter) begin
                m_stk_pc.push_back(resume_pc);
                m_stk_lvl.push_back(m_lvl);
                m_lvl = cand;
                m_pend[cand-1] = 0;
                exp_q.push_back('{vec: vec_of(cand), pc: resume_pc, lvl: 2'(cand)});
                m_busy = 2;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            for (int k = 0; k < 3; k++) begin
                if (ir[k] && !m_irq[k]) m_pend[k] = 1;
                m_irq[k] = ir[k];
            end
        end
    end

    // Monitor: compares visible state each cycle and consumes predicted entries.
    always @(negedge clk) begin
        if (run_mon) begin
            bit want;
            check("level", 32'(level), 32'(m_lvl));
            check("pending", 32'(pending), 32'(m_pend_vec()));
            check("epc", epc, m_epc());
            want = (exp_q.size() != 0);
            check("int_req", 32'(int_req), 32'(want));
            if (want) begin
                exp_t e;
                e = exp_q.pop_front();
                if (int_req) begin
                    check("int_vec", int_vec, e.vec);
                    check("entry_epc", epc, e.pc);
                    check("entry_level", 32'(level), 32'(e.lvl));
                end
            end
        end
    end

    task automatic step(input logic [2:0] i, input logic a, input logic e,
                        input logic [31:0] pc, input logic c);
        ir = i; accept = a; eret = e; resume_pc = pc; clr = c;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(3'b000, 1'b1, 1'b0, 32'h0000_0aa0, 1'b0);
    endtask

    task automatic pulse(input logic [2:0] i, input logic [31:0] pc);
        step(i, 1'b1, 1'b0, pc, 1'b0);
    endtask

    task automatic do_eret();
        step(3'b000, 1'b1, 1'b1, 32'h0000_0bb0, 1'b0);
    endtask

    initial begin
        step(3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
        step(3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
        run_mon = 1'b1;
        step(3'b000, 1'b0, 1'b1, 32'h0, 1'b1);

        // single request, then nesting and unwinding
        pulse(3'b001, 32'h40);   idle(5);
        pulse(3'b100, 32'h1008); idle(5);
        do_eret(); idle(2);
        do_eret(); idle(3);

        // lower priority blocked at level 2 until eret
        pulse(3'b010, 32'h200); idle(5);
        pulse(3'b001, 32'h204); idle(5);
        do_eret(); idle(5);
        do_eret(); idle(3);

        // simultaneous sources, serviced 3 then 2 then 1
        pulse(3'b111, 32'h300); idle(6);
        do_eret(); idle(6);
        do_eret(); idle(6);
        do_eret(); idle(3);

        // eret colliding with a higher candidate
        pulse(3'b001, 32'h400); idle(5);
        pulse(3'b100, 32'h404);
        do_eret(); idle(5);
        do_eret(); idle(3);

        // accept low holds pending without entry
        step(3'b010, 1'b0, 1'b0, 32'h500, 1'b0);
        for (int j = 0; j < 10; j++) step(3'b000, 1'b0, 1'b0, 32'h500, 1'b0);
        idle(5);
        do_eret(); idle(3);

        // reset during ENTER, then eret on empty stack
        pulse(3'b001, 32'h600);
        idle(1);
        step(3'b000, 1'b1, 1'b0, 32'h604, 1'b1);
        idle(2);
        do_eret(); idle(3);

        // randomized traffic
        for (int j = 0; j < 4000; j++) begin
            logic [2:0] ri;
            ri = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(0, 7)) : ir;
            step(ri, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 1,
                 $urandom & 32'hffff_fffc, $urandom_range(0, 299) == 0);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
